// File: rtl/xilinx_reset_boot_sequencer.sv
// Board-level bring-up: holds the SoC in reset until the PLL is locked and settled,
// latches boot straps at reset release, captures the first SoC exit and shows it on an LED.
module xilinx_reset_boot_sequencer #(
  parameter int SETTLE_CYCLES        = 1024,
  parameter int RESET_HOLD_CYCLES    = 64,
  parameter int CLK_LED_COUNT_LENGTH = 27
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        pll_locked_i,
  input  logic        boot_select_i,
  input  logic        execute_from_flash_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        core_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        exit_seen_o,
  output logic [31:0] exit_code_o,
  output logic        status_led_o,
  output logic        clk_led_o
);

  localparam int MAX_CYC = (SETTLE_CYCLES > RESET_HOLD_CYCLES) ? SETTLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int LED_W   = CLK_LED_COUNT_LENGTH;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_W-1:0]   led_cnt_q, led_cnt_d;
  logic [1:0]         lock_sync_q, bs_sync_q, eff_sync_q;
  logic               locked_s, bs_s, eff_s;
  logic               core_rst_n_q, core_rst_n_d;
  logic               boot_sel_q, boot_sel_d;
  logic               eff_q, eff_d;
  logic               exit_seen_q, exit_seen_d;
  logic [31:0]        exit_code_q, exit_code_d;
  logic               status_led_q, status_led_d;

  assign locked_s = lock_sync_q[1];
  assign bs_s     = bs_sync_q[1];
  assign eff_s    = eff_sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_sel_d  = boot_sel_q;
    eff_d       = eff_q;
    exit_seen_d = exit_seen_q;
    exit_code_d = exit_code_q;
    led_cnt_d   = led_cnt_q + LED_W'(1);

    // Lock loss is checked first in every active state so it wins over any other event.
    case (state_q)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          boot_sel_d = bs_s;
          eff_d      = eff_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (exit_valid_i) begin
          state_d = ST_DONE;
          // The first captured code survives lock-loss reruns; only rst_n clears it.
          if (!exit_seen_q) begin
            exit_seen_d = 1'b1;
            exit_code_d = exit_value_i;
          end
        end
      end
      ST_DONE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_DONE);

  always_comb begin
    status_led_d = 1'b0;
    case (state_d)
      ST_SETTLE, ST_HOLD: status_led_d = 1'b1;
      ST_RUN:             status_led_d = led_cnt_d[LED_W-1];
      ST_DONE:            status_led_d = (exit_code_d == 32'd0) ? 1'b1 : led_cnt_d[LED_W-3];
      default:            status_led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q  <= '0;
      bs_sync_q    <= '0;
      eff_sync_q   <= '0;
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      led_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      boot_sel_q   <= 1'b0;
      eff_q        <= 1'b0;
      exit_seen_q  <= 1'b0;
      exit_code_q  <= '0;
      status_led_q <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], pll_locked_i};
      bs_sync_q    <= {bs_sync_q[0], boot_select_i};
      eff_sync_q   <= {eff_sync_q[0], execute_from_flash_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      led_cnt_q    <= led_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      boot_sel_q   <= boot_sel_d;
      eff_q        <= eff_d;
      exit_seen_q  <= exit_seen_d;
      exit_code_q  <= exit_code_d;
      status_led_q <= status_led_d;
    end
  end

  assign core_rst_no          = core_rst_n_q;
  assign boot_select_o        = boot_sel_q;
  assign execute_from_flash_o = eff_q;
  assign exit_seen_o          = exit_seen_q;
  assign exit_code_o          = exit_code_q;
  assign status_led_o         = status_led_q;
  assign clk_led_o            = led_cnt_q[LED_W-1];

endmodule

// File: tb/tb_xilinx_reset_boot_sequencer.sv
// Bench for xilinx_reset_boot_sequencer: directed vector table, corner sequences,
// and randomized traffic checked every cycle against a phase/elapsed-time model.
module tb_xilinx_reset_boot_sequencer;

  localparam int S   = 4;
  localparam int H   = 3;
  localparam int LEN = 6;

  logic        clk_gen = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock_i = 1'b0, bs_i = 1'b0, eff_i = 1'b0, ev_i = 1'b0;
  logic [31:0] val_i = '0;
  logic        core_rst_no, boot_select_o, execute_from_flash_o, exit_seen_o;
  logic [31:0] exit_code_o;
  logic        status_led_o, clk_led_o;

  xilinx_reset_boot_sequencer #(
    .SETTLE_CYCLES(S), .RESET_HOLD_CYCLES(H), .CLK_LED_COUNT_LENGTH(LEN)
  ) dut (
    .clk_gen(clk_gen), .rst_n(rst_n),
    .pll_locked_i(lock_i), .boot_select_i(bs_i), .execute_from_flash_i(eff_i),
    .exit_valid_i(ev_i), .exit_value_i(val_i),
    .core_rst_no(core_rst_no), .boot_select_o(boot_select_o),
    .execute_from_flash_o(execute_from_flash_o), .exit_seen_o(exit_seen_o),
    .exit_code_o(exit_code_o), .status_led_o(status_led_o), .clk_led_o(clk_led_o)
  );

  always #5 clk_gen = ~clk_gen;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: "streak" = consecutive edges the synchronised lock has been seen high.
  // 0 -> waiting, 1..S -> settle, S+1..S+H -> hold, beyond -> running/done.
  int          streak;
  bit          done_m, seen_m, bso_m, effo_m;
  logic [31:0] code_m;
  bit   [1:0]  lp, bp, ep;
  int          led_m;

  task automatic model_reset();
    streak = 0; done_m = 0; seen_m = 0; bso_m = 0; effo_m = 0;
    code_m = '0; lp = '0; bp = '0; ep = '0; led_m = 0;
  endtask

  task automatic model_step();
    bit ls, bss, effs;
    int prev;
    ls = lp[1]; bss = bp[1]; effs = ep[1]; prev = streak;
    if (!ls) begin
      streak = 0;
      done_m = 0;
    end else begin
      if (streak <= S + H) streak++;
      if (prev == S + H) begin
        bso_m  = bss;
        effo_m = effs;
      end
      if (prev > S + H && !done_m && ev_i) begin
        done_m = 1;
        if (!seen_m) begin
          seen_m = 1;
          code_m = val_i;
        end
      end
    end
    lp = {lp[0], lock_i}; bp = {bp[0], bs_i}; ep = {ep[0], eff_i};
    led_m = (led_m + 1) % (1 << LEN);
  endtask

  function automatic bit exp_status();
    if (streak == 0)          return 1'b0;
    else if (streak <= S + H) return 1'b1;
    else if (!done_m)         return 1'((led_m >> (LEN - 1)) & 1);
    else if (code_m == 0)     return 1'b1;
    else                      return 1'((led_m >> (LEN - 3)) & 1);
  endfunction

  task automatic check1(string name, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_all();
    check1("core_rst_no", core_rst_no, streak > S + H);
    check1("boot_select_o", boot_select_o, bso_m);
    check1("execute_from_flash_o", execute_from_flash_o, effo_m);
    check1("exit_seen_o", exit_seen_o, seen_m);
    check32("exit_code_o", exit_code_o, code_m);
    check1("status_led_o", status_led_o, exp_status());
    check1("clk_led_o", clk_led_o, 1'((led_m >> (LEN - 1)) & 1));
  endtask

  task automatic cycle();
    @(posedge clk_gen);
    model_step();
    @(negedge clk_gen);
    compare_all();
  endtask

  // Called at a negedge: asserts rst_n, checks outputs cleared before any edge, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check1("rst core_rst_no", core_rst_no, 1'b0);
    check1("rst boot_select_o", boot_select_o, 1'b0);
    check1("rst exit_seen_o", exit_seen_o, 1'b0);
    check32("rst exit_code_o", exit_code_o, 32'd0);
    check1("rst status_led_o", status_led_o, 1'b0);
    check1("rst clk_led_o", clk_led_o, 1'b0);
    check1("rst execute_from_flash_o", execute_from_flash_o, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          lock, bs, eff, ev;
    logic [31:0] val;
    int          n;
    bit          e_rst, e_seen, e_bs;
    logic [31:0] e_code;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int waited, toggles, lock_low;
    logic prev_led;

    //         lock bs eff ev  val           n  rst seen bs  code
    vecs[0]  = '{1, 1, 0, 0, 32'h0,         9, 0, 0, 0, 32'h0};
    vecs[1]  = '{1, 1, 0, 0, 32'h0,         1, 1, 0, 1, 32'h0};
    vecs[2]  = '{1, 0, 0, 0, 32'h0,         3, 1, 0, 1, 32'h0};
    vecs[3]  = '{1, 0, 0, 1, 32'h0,         1, 1, 1, 1, 32'h0};
    vecs[4]  = '{1, 0, 0, 1, 32'hDEADBEEF,  1, 1, 1, 1, 32'h0};
    vecs[5]  = '{1, 0, 0, 0, 32'h0,         4, 1, 1, 1, 32'h0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,         3, 0, 1, 1, 32'h0};
    vecs[7]  = '{1, 0, 0, 0, 32'h0,         9, 0, 1, 1, 32'h0};
    vecs[8]  = '{1, 0, 0, 0, 32'h0,         1, 1, 1, 0, 32'h0};
    vecs[9]  = '{1, 0, 0, 1, 32'h5,         1, 1, 1, 0, 32'h0};
    vecs[10] = '{1, 0, 0, 0, 32'h0,         2, 1, 1, 0, 32'h0};

    model_reset();
    repeat (2) @(negedge clk_gen);
    compare_all();
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      lock_i = vecs[k].lock; bs_i = vecs[k].bs; eff_i = vecs[k].eff;
      ev_i = vecs[k].ev; val_i = vecs[k].val;
      repeat (vecs[k].n) cycle();
      check1($sformatf("vec%0d core_rst_no", k), core_rst_no, vecs[k].e_rst);
      check1($sformatf("vec%0d exit_seen_o", k), exit_seen_o, vecs[k].e_seen);
      check1($sformatf("vec%0d boot_select_o", k), boot_select_o, vecs[k].e_bs);
      check32($sformatf("vec%0d exit_code_o", k), exit_code_o, vecs[k].e_code);
    end
    ev_i = 0;

    // Fresh reset, reach RUN, then pulse rst_n mid-RUN.
    bs_i = 1; eff_i = 0;
    do_reset();
    repeat (10) cycle();
    check1("pre-pulse RUN", core_rst_no, 1'b1);
    bs_i = 0; eff_i = 1;
    do_reset();

    // Lock glitch at HOLD cnt=1, then full settle+hold replay.
    repeat (6) cycle();
    lock_i = 0;
    repeat (3) cycle();
    lock_i = 1;
    waited = 0;
    while (!core_rst_no && waited < 40) begin
      cycle();
      waited++;
    end
    check32("relock cycles to RUN", waited, 10);
    check1("fresh strap bs", boot_select_o, 1'b0);
    check1("fresh strap eff", execute_from_flash_o, 1'b1);

    // Failing exit: LED blinks from counter bit LEN-3 (period 16).
    ev_i = 1; val_i = 32'h1;
    cycle();
    ev_i = 0;
    check32("fail code", exit_code_o, 32'h1);
    toggles = 0;
    prev_led = status_led_o;
    repeat (32) begin
      cycle();
      if (status_led_o !== prev_led) toggles++;
      prev_led = status_led_o;
    end
    check32("fail blink toggles in 32", toggles, 4);

    // Lock loss in DONE keeps the captured code.
    lock_i = 0;
    repeat (3) cycle();
    check1("done lockloss core_rst_no", core_rst_no, 1'b0);
    check32("done lockloss code kept", exit_code_o, 32'h1);
    lock_i = 1;

    // Randomized traffic against the model.
    lock_low = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      if (lock_low > 0) begin
        lock_i = 0;
        lock_low--;
      end else begin
        lock_i = 1;
        if ($urandom_range(0, 39) == 0) lock_low = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 19) == 0) bs_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) eff_i = 1'($urandom_range(0, 1));
      ev_i  = ($urandom_range(0, 29) == 0);
      val_i = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
